// File: rtl/sprite_anim_addr_gen.sv
// ----------------------------------------------------------------------------
// sprite_anim_addr_gen
//
// Upstream stage of the sprite ROM / palette pixel path. Places one
// multi-frame sprite (frames stacked back-to-back in a single ROM) at a
// screen position, runs a play-once animation advanced by frame_start, and
// produces a pipelined ROM address plus a sprite_hit flag aligned with the
// ROM data that the downstream colour stage registers one clock later.
//
// Ports:
//   vga_clk      pixel clock, all state on posedge
//   reset_n      asynchronous active-low reset
//   DrawX/DrawY  current pixel column/row
//   frame_start  one-cycle pulse per frame (vertical blank)
//   pos_x/pos_y  sprite top-left position, latched on frame_start
//   trigger      one-cycle pulse starting the animation
//   face_left    (SPRITE_HFLIP_EN only) horizontal mirror, latched on frame_start
//   rom_address  sprite ROM address, 2 cycles after DrawX/DrawY
//   sprite_hit   pixel inside sprite box, 3 cycles after DrawX/DrawY
//   anim_frame   animation frame being displayed
//   busy         animation playing
//   anim_done    animation finished, holding last frame
//
// Optional feature macro: SPRITE_HFLIP_EN (adds face_left and mirroring).
// ----------------------------------------------------------------------------
module sprite_anim_addr_gen #(
    parameter int SPR_W      = 50,
    parameter int SPR_H      = 64,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 6,
    parameter int ADDR_W     = 14,
    localparam int FW        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              trigger,
`ifdef SPRITE_HFLIP_EN
    input  logic              face_left,
`endif
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_hit,
    output logic [FW-1:0]     anim_frame,
    output logic              busy,
    output logic              anim_done
);

    localparam int CW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [CW-1:0]     LAST_HOLD  = CW'(FRAME_HOLD - 1);
    localparam logic [FW-1:0]     LAST_FRAME = FW'(NUM_FRAMES - 1);
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0] ROW_SIZE   = ADDR_W'(SPR_W);

    typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;

    logic [9:0] px;
    logic [9:0] py;
`ifdef SPRITE_HFLIP_EN
    logic       face_left_r;
`endif

    logic signed [10:0] lx;
    logic signed [10:0] ly;
    logic               in_box;

    logic [9:0]         lx_r;
    logic [9:0]         ly_r;
    logic               in_box_r;
    logic               hit_pipe;

    logic [ADDR_W-1:0]  col;
    logic [ADDR_W-1:0]  addr_next;

    // Position (and facing) only change at frame_start so a frame is never
    // drawn half at the old place and half at the new one.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            px <= '0;
            py <= '0;
`ifdef SPRITE_HFLIP_EN
            face_left_r <= 1'b0;
`endif
        end else if (frame_start) begin
            px <= pos_x;
            py <= pos_y;
`ifdef SPRITE_HFLIP_EN
            face_left_r <= face_left;
`endif
        end
    end

    // Sprite-local coordinates. The 11-bit signed range covers any
    // DrawX - px, so a negative result simply means left of/above the box.
    always_comb begin
        lx     = $signed({1'b0, DrawX}) - $signed({1'b0, px});
        ly     = $signed({1'b0, DrawY}) - $signed({1'b0, py});
        in_box = !lx[10] && (lx[9:0] < 10'(SPR_W)) &&
                 !ly[10] && (ly[9:0] < 10'(SPR_H));
    end

    // Stage-2 address arithmetic. anim_frame only moves during vertical
    // blank, so using its live value here never splits a frame.
    always_comb begin
        col = ADDR_W'(lx_r);
`ifdef SPRITE_HFLIP_EN
        if (face_left_r)
            col = ADDR_W'(SPR_W - 1) - ADDR_W'(lx_r);
`endif
        addr_next = ADDR_W'(anim_frame) * FRAME_SIZE
                  + ADDR_W'(ly_r) * ROW_SIZE
                  + col;
    end

    // Three-stage pixel pipeline: local coords, ROM address, hit flag.
    // sprite_hit trails rom_address by one cycle to line up with ROM data.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            lx_r        <= '0;
            ly_r        <= '0;
            in_box_r    <= 1'b0;
            rom_address <= '0;
            hit_pipe    <= 1'b0;
            sprite_hit  <= 1'b0;
        end else begin
            lx_r        <= lx[9:0];
            ly_r        <= ly[9:0];
            in_box_r    <= in_box;
            rom_address <= in_box_r ? addr_next : '0;
            hit_pipe    <= in_box_r;
            sprite_hit  <= hit_pipe;
        end
    end

    // Play-once animation. A trigger in IDLE/HOLD restarts from frame 0 and
    // swallows a coincident frame_start; while playing, trigger is ignored.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            anim_frame <= '0;
            hold_cnt   <= '0;
            busy       <= 1'b0;
            anim_done  <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (trigger) begin
                        state      <= PLAY;
                        anim_frame <= '0;
                        hold_cnt   <= '0;
                        busy       <= 1'b1;
                        anim_done  <= 1'b0;
                    end
                end
                PLAY: begin
                    if (frame_start) begin
                        if (hold_cnt == LAST_HOLD) begin
                            hold_cnt <= '0;
                            if (anim_frame == LAST_FRAME) begin
                                state     <= HOLD;
                                busy      <= 1'b0;
                                anim_done <= 1'b1;
                            end else begin
                                anim_frame <= anim_frame + 1'b1;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    anim_frame <= '0;
                    hold_cnt   <= '0;
                    busy       <= 1'b0;
                    anim_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_anim_addr_gen.sv
// ----------------------------------------------------------------------------
// tb_sprite_anim_addr_gen
//
// Directed bench for sprite_anim_addr_gen (default parameters, 50x64 sprite,
// 4 frames, 6 frame_start pulses per frame). Pixel vectors push their
// expected address/hit into a queue; a monitor aligns them with the
// pipeline latency and compares. FSM outputs are checked directly.
// Optional feature macro: SPRITE_HFLIP_EN.
// ----------------------------------------------------------------------------
module tb_sprite_anim_addr_gen;

    typedef struct {
        bit          chk;
        logic [13:0] addr;
        bit          hit;
        string       name;
    } exp_t;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        frame_start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        trigger = 1'b0;
`ifdef SPRITE_HFLIP_EN
    logic        face_left = 1'b0;
`endif
    logic [13:0] rom_address;
    logic        sprite_hit;
    logic [1:0]  anim_frame;
    logic        busy;
    logic        anim_done;

    int   checks   = 0;
    int   failures = 0;
    exp_t stim_q[$];

    sprite_anim_addr_gen dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_start (frame_start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .trigger     (trigger),
`ifdef SPRITE_HFLIP_EN
        .face_left   (face_left),
`endif
        .rom_address (rom_address),
        .sprite_hit  (sprite_hit),
        .anim_frame  (anim_frame),
        .busy        (busy),
        .anim_done   (anim_done)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // One call = one pixel clock; every cycle pushes a scoreboard entry.
    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                                 input logic fs, input logic trg, input bit chk,
                                 input logic [13:0] addr, input bit hit,
                                 input string name);
        @(negedge vga_clk);
        DrawX       = x;
        DrawY       = y;
        frame_start = fs;
        trigger     = trg;
        stim_q.push_back('{chk, addr, hit, name});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, "idle");
    endtask

    task automatic pulse(input logic fs, input logic trg);
        applyStimulus(10'd0, 10'd0, fs, trg, 1'b0, 14'd0, 1'b0, "ctl");
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y,
                       input logic [13:0] addr, input bit hit, input string name);
        applyStimulus(x, y, 1'b0, 1'b0, 1'b1, addr, hit, name);
    endtask

    task automatic checkFsm(input string name, input logic [1:0] frame,
                            input logic b, input logic d);
        checkOutput({name, "_frame"}, 32'(anim_frame), 32'(frame));
        checkOutput({name, "_busy"},  32'(busy),       32'(b));
        checkOutput({name, "_done"},  32'(anim_done),  32'(d));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_addr"}, 32'(rom_address), 32'd0);
        checkOutput({name, "_hit"},  32'(sprite_hit),  32'd0);
        checkFsm(name, 2'd0, 1'b0, 1'b0);
    endtask

    // Monitor: entry captured at edge k gives rom_address after edge k+1
    // and sprite_hit after edge k+2.
    initial begin
        exp_t a1 = '{1'b0, 14'd0, 1'b0, ""};
        exp_t a2 = '{1'b0, 14'd0, 1'b0, ""};
        forever begin
            @(posedge vga_clk);
            #1;
            if (a1.chk) checkOutput({a1.name, "_addr"}, 32'(rom_address), 32'(a1.addr));
            if (a2.chk) checkOutput({a2.name, "_hit"},  32'(sprite_hit),  32'(a2.hit));
            a2 = a1;
            if (stim_q.size() > 0) a1 = stim_q.pop_front();
            else a1 = '{1'b0, 14'd0, 1'b0, ""};
        end
    end

    initial begin
        // Reset state
        idle(2);
        checkAllZero("reset");
        reset_n = 1'b1;

        // Latch (100,200) while idle and scan the box edges
        pos_x = 10'd100;
        pos_y = 10'd200;
        pulse(1'b1, 1'b0);
        pix(10'd100, 10'd200, 14'd0,    1'b1, "topleft");
        pix(10'd149, 10'd263, 14'd3199, 1'b1, "botright");
        pix(10'd150, 10'd263, 14'd0,    1'b0, "right_out");
        pix(10'd99,  10'd200, 14'd0,    1'b0, "left_out");
        pix(10'd100, 10'd199, 14'd0,    1'b0, "above_out");
        pix(10'd120, 10'd210, 14'd520,  1'b1, "inner");
        idle(1);
        checkFsm("idle", 2'd0, 1'b0, 1'b0);

        // Animation: trigger then 24 frame_start pulses
        pulse(1'b0, 1'b1);
        idle(1);
        checkFsm("trig_play", 2'd0, 1'b1, 1'b0);
        for (int n = 1; n <= 24; n++) begin
            if (n == 4) begin
                pulse(1'b0, 1'b1);
                idle(1);
                checkFsm("trig_ignored", 2'd0, 1'b1, 1'b0);
            end
            pulse(1'b1, n == 8);
            idle(1);
            checkFsm($sformatf("pulse%0d", n), (n == 24) ? 2'd3 : 2'(n / 6),
                     n < 24, n == 24);
        end
        pix(10'd100, 10'd200, 14'd9600,  1'b1, "hold_topleft");
        pix(10'd149, 10'd263, 14'd12799, 1'b1, "hold_botright");
        idle(2);

        // trigger with frame_start in HOLD: restart, that pulse not counted
        pulse(1'b1, 1'b1);
        idle(1);
        checkFsm("rehold_trig", 2'd0, 1'b1, 1'b0);
        for (int n = 1; n <= 6; n++) begin
            pulse(1'b1, 1'b0);
            idle(1);
            if (n == 5) checkFsm("restart_p5", 2'd0, 1'b1, 1'b0);
            if (n == 6) checkFsm("restart_p6", 2'd1, 1'b1, 1'b0);
        end

        // Mid-frame position change waits for frame_start
        pos_x = 10'd300;
        pix(10'd100, 10'd200, 14'd3200, 1'b1, "pos_old_hit");
        pix(10'd300, 10'd200, 14'd0,    1'b0, "pos_new_early");
        pulse(1'b1, 1'b0);
        pix(10'd300, 10'd200, 14'd3200, 1'b1, "pos_new_hit");
        pix(10'd349, 10'd263, 14'd6399, 1'b1, "pos_new_corner");
        pix(10'd100, 10'd200, 14'd0,    1'b0, "pos_old_gone");
        idle(3);

        // Asynchronous reset mid-PLAY
        checkFsm("pre_reset", 2'd1, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        idle(2);
        reset_n = 1'b1;

        // Edge clipping near the bottom-right of the visible area
        pos_x = 10'd620;
        pos_y = 10'd450;
        pulse(1'b1, 1'b0);
        pix(10'd639, 10'd479, 14'd1469, 1'b1, "clip_corner");
        for (int x = 0; x <= 5; x++)
            pix(10'(x), 10'd480, 14'd0, 1'b0, "clip_nextline");
        pix(10'd619, 10'd479, 14'd0,    1'b0, "clip_left_out");
        pix(10'd669, 10'd513, 14'd3199, 1'b1, "blank_corner");
        pix(10'd670, 10'd513, 14'd0,    1'b0, "blank_right_out");

`ifdef SPRITE_HFLIP_EN
        // Horizontal mirror
        face_left = 1'b1;
        pos_x = 10'd100;
        pos_y = 10'd200;
        pulse(1'b1, 1'b0);
        pix(10'd100, 10'd200, 14'd49,  1'b1, "hflip_left");
        pix(10'd149, 10'd201, 14'd50,  1'b1, "hflip_right");
        face_left = 1'b0;
        pulse(1'b1, 1'b0);
        pix(10'd100, 10'd200, 14'd0,   1'b1, "hflip_off");
`endif

        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
